lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 36 +++
 rtl/lsu_ctrl.sv | 104 ++++++++++
 tb/tb_lsu_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_if
// Description : Request handshake, RAM bus and register-file write port of
//               the load/store controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic [4:0]  req_rd;
    logic [63:0] ram_address;
    logic [63:0] ram_in;
    logic        ram_write;
    logic [63:0] ram_out;
    logic        rf_write;
    logic [4:0]  rf_writeReg;
    logic [63:0] rf_data;
    logic        done;

    modport slave (
        input  req_valid, req_store, req_addr, req_data, req_rd, ram_out,
        output req_ready, ram_address, ram_in, ram_write,
               rf_write, rf_writeReg, rf_data, done
    );

    modport master (
        output req_valid, req_store, req_addr, req_data, req_rd, ram_out,
        input  req_ready, ram_address, ram_in, ram_write,
               rf_write, rf_writeReg, rf_data, done
    );
endinterface
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl
// Description : Single-outstanding load/store controller between a request
//               port, a falling-edge RAM and a register file.
//               Define LSU_CTRL_STATS_EN to add load/store completion counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl (
    input  wire logic   clock,
    input  wire logic   reset,
`ifdef LSU_CTRL_STATS_EN
    output logic [15:0] load_count,
    output logic [15:0] store_count,
`endif
    lsu_ctrl_if.slave   bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ST_WR   = 2'd1;
    localparam logic [1:0] S_LD_ADDR = 2'd2;
    localparam logic [1:0] S_LD_WB   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [7:0]  addr_q;
    logic [63:0] data_q;
    logic [4:0]  rd_q;
    logic        store_q;
    logic        w_handshake;

    assign w_handshake = bus.req_valid && (state_q == S_IDLE);

    // Request fields are captured only on the handshake, so later input
    // changes cannot disturb an operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 8'h00;
            data_q  <= 64'h0;
            rd_q    <= 5'd0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_handshake) begin
                addr_q  <= bus.req_addr;
                data_q  <= bus.req_data;
                rd_q    <= bus.req_rd;
                store_q <= bus.req_store;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_handshake) begin
                    state_d = bus.req_store ? S_ST_WR : S_LD_ADDR;
                end
            end
            S_ST_WR:   state_d = S_IDLE;
            S_LD_ADDR: state_d = S_LD_WB;
            S_LD_WB:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready   = (state_q == S_IDLE);
        bus.ram_address = {addr_q, 56'h0};
        bus.ram_in      = data_q;
        bus.ram_write   = (state_q == S_ST_WR) && store_q;
        bus.rf_write    = (state_q == S_LD_WB);
        bus.rf_writeReg = rd_q;
        bus.rf_data     = bus.ram_out;
        bus.done        = (state_q == S_ST_WR) || (state_q == S_LD_WB);
    end

`ifdef LSU_CTRL_STATS_EN
    logic [15:0] load_cnt_q;
    logic [15:0] store_cnt_q;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_cnt_q  <= 16'h0000;
            store_cnt_q <= 16'h0000;
        end else begin
            if (state_q == S_LD_WB) begin
                load_cnt_q <= load_cnt_q + 16'h0001;
            end
            if ((state_q == S_ST_WR) && store_q) begin
                store_cnt_q <= store_cnt_q + 16'h0001;
            end
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl
// Description : Directed vector bench for lsu_ctrl with a falling-edge RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;
    localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] D2 = 64'hCAFEF00D_55AA55AA;
    localparam logic [63:0] D3 = 64'h0000_0000_0000_1234;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] mem [256];

    lsu_ctrl_if bus ();

`ifdef LSU_CTRL_STATS_EN
    logic [15:0] load_count, store_count;
    lsu_ctrl dut (.clock(clk), .reset(rst), .load_count(load_count),
                  .store_count(store_count), .bus(bus));
`else
    lsu_ctrl dut (.clock(clk), .reset(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // RAM: writes commit and reads sample the address on the falling edge
    always @(negedge clk) begin
        if (bus.ram_write) mem[bus.ram_address[63:56]] = bus.ram_in;
        bus.ram_out = mem[bus.ram_address[63:56]];
    end

    typedef struct {
        logic        rst, valid, store;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        e_ready, e_wr, e_rf, e_done;
        logic [7:0]  e_idx;
        logic [63:0] e_in;
        logic [4:0]  e_rd;
        logic [63:0] e_rfd;
    } vec_t;

    vec_t tv [22];

    function automatic vec_t mk(input logic r, input logic v, input logic s,
                                input logic [7:0] a, input logic [63:0] d,
                                input logic [4:0] rd, input logic er,
                                input logic ew, input logic ef, input logic ed,
                                input logic [7:0] ei, input logic [63:0] ein,
                                input logic [4:0] erd, input logic [63:0] erfd);
        vec_t t;
        t.rst = r; t.valid = v; t.store = s; t.addr = a; t.data = d; t.rd = rd;
        t.e_ready = er; t.e_wr = ew; t.e_rf = ef; t.e_done = ed;
        t.e_idx = ei; t.e_in = ein; t.e_rd = erd; t.e_rfd = erfd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic st, input logic [7:0] a, input logic [63:0] d,
                         input logic [4:0] r, output int lat,
                         output logic [63:0] rfd, output logic [4:0] rfr);
        int n;
        n = 0;
        while (!bus.req_ready && n < 8) begin
            @(posedge clk); #1; n++;
        end
        bus.req_valid = 1'b1; bus.req_store = st; bus.req_addr = a;
        bus.req_data = d; bus.req_rd = r;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.done && lat < 6) begin
            @(posedge clk); #1; lat++;
        end
        rfd = bus.rf_data;
        rfr = bus.rf_writeReg;
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        logic [63:0] rfd;
        logic [4:0]  rfr;
        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_addr = 8'h00;
        bus.req_data = 64'h0; bus.req_rd = 5'd0;

        // rst, valid, store, addr, data, rd | ready, wr, rf, done, idx, ram_in, rd, rf_data
        tv[0]  = mk(0,0,0,8'h00,64'h0,5'd0,   1,0,0,0, 8'h00,64'h0,5'd0,64'h0);
        tv[1]  = mk(0,1,1,8'h05,D1,5'd0,      1,0,0,0, 8'h00,64'h0,5'd0,64'h0);
        tv[2]  = mk(0,0,0,8'h00,64'h0,5'd0,   0,1,0,1, 8'h05,D1,5'd0,64'h0);
        tv[3]  = mk(0,1,0,8'h05,64'h0,5'd7,   1,0,0,0, 8'h05,D1,5'd0,64'h0);
        tv[4]  = mk(0,1,1,8'h33,D3,5'd9,      0,0,0,0, 8'h05,64'h0,5'd0,64'h0);
        tv[5]  = mk(0,1,1,8'h33,D3,5'd9,      0,0,1,1, 8'h05,64'h0,5'd7,D1);
        tv[6]  = mk(0,1,1,8'h33,D3,5'd9,      1,0,0,0, 8'h05,64'h0,5'd0,64'h0);
        tv[7]  = mk(0,1,0,8'h33,64'h0,5'd3,   0,1,0,1, 8'h33,D3,5'd0,64'h0);
        tv[8]  = mk(0,1,0,8'h33,64'h0,5'd3,   1,0,0,0, 8'h33,D3,5'd0,64'h0);
        tv[9]  = mk(0,1,1,8'hFF,D2,5'd1,      0,0,0,0, 8'h33,64'h0,5'd0,64'h0);
        tv[10] = mk(0,1,1,8'hFF,D2,5'd1,      0,0,1,1, 8'h33,64'h0,5'd3,D3);
        tv[11] = mk(0,1,1,8'hFF,D2,5'd1,      1,0,0,0, 8'h33,64'h0,5'd0,64'h0);
        tv[12] = mk(0,1,0,8'hFF,64'h0,5'd31,  0,1,0,1, 8'hFF,D2,5'd0,64'h0);
        tv[13] = mk(0,1,0,8'hFF,64'h0,5'd31,  1,0,0,0, 8'hFF,D2,5'd0,64'h0);
        tv[14] = mk(0,0,0,8'h00,64'h0,5'd0,   0,0,0,0, 8'hFF,64'h0,5'd0,64'h0);
        tv[15] = mk(0,0,0,8'h00,64'h0,5'd0,   0,0,1,1, 8'hFF,64'h0,5'd31,D2);
        tv[16] = mk(1,1,1,8'h44,D3,5'd2,      1,0,0,0, 8'hFF,64'h0,5'd0,64'h0);
        tv[17] = mk(0,0,0,8'h00,64'h0,5'd0,   1,0,0,0, 8'h00,64'h0,5'd0,64'h0);
        tv[18] = mk(0,1,0,8'h05,64'h0,5'd12,  1,0,0,0, 8'h00,64'h0,5'd0,64'h0);
        tv[19] = mk(1,0,0,8'h00,64'h0,5'd0,   0,0,0,0, 8'h05,64'h0,5'd0,64'h0);
        tv[20] = mk(0,0,0,8'h00,64'h0,5'd0,   1,0,0,0, 8'h00,64'h0,5'd0,64'h0);
        tv[21] = mk(0,0,0,8'h00,64'h0,5'd0,   1,0,0,0, 8'h00,64'h0,5'd0,64'h0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_ram_write", bus.ram_write, 0);
        chk("reset_rf_write", bus.rf_write, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_ram_address", bus.ram_address, 0);
        chk("reset_ram_in", bus.ram_in, 0);
        chk("reset_rf_writeReg", bus.rf_writeReg, 0);

        for (int i = 0; i < 22; i++) begin
            rst = tv[i].rst;
            bus.req_valid = tv[i].valid; bus.req_store = tv[i].store;
            bus.req_addr = tv[i].addr; bus.req_data = tv[i].data;
            bus.req_rd = tv[i].rd;
            chk($sformatf("v%0d_ready", i), bus.req_ready, tv[i].e_ready);
            chk($sformatf("v%0d_ram_write", i), bus.ram_write, tv[i].e_wr);
            chk($sformatf("v%0d_rf_write", i), bus.rf_write, tv[i].e_rf);
            chk($sformatf("v%0d_done", i), bus.done, tv[i].e_done);
            chk($sformatf("v%0d_ram_address", i), bus.ram_address, {tv[i].e_idx, 56'h0});
            chk($sformatf("v%0d_ram_in", i), bus.ram_in, tv[i].e_in);
            if (tv[i].e_rf) begin
                chk($sformatf("v%0d_rf_writeReg", i), bus.rf_writeReg, tv[i].e_rd);
                chk($sformatf("v%0d_rf_data", i), bus.rf_data, tv[i].e_rfd);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;

        // Reset-cleared rd must not leak into later cycles
        chk("post_reset_rf_writeReg", bus.rf_writeReg, 0);

        do_op(1'b0, 8'h05, 64'h0, 5'd12, lat, rfd, rfr);
        chk("load_latency", lat, 2);
        chk("load_rf_data", rfd, D1);
        chk("load_rf_writeReg", rfr, 12);
        do_op(1'b1, 8'h00, 64'h5, 5'd0, lat, rfd, rfr);
        chk("store_latency", lat, 1);
        chk("store_ready_after", bus.req_ready, 1);
        do_op(1'b0, 8'h00, 64'h0, 5'd4, lat, rfd, rfr);
        chk("load0_rf_data", rfd, 64'h5);
        do_op(1'b0, 8'hFF, 64'h0, 5'd30, lat, rfd, rfr);
        chk("loadFF_rf_data", rfd, D2);

`ifdef LSU_CTRL_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("stats_reset_load", load_count, 0);
        chk("stats_reset_store", store_count, 0);
        do_op(1'b0, 8'h01, 64'h0, 5'd1, lat, rfd, rfr);
        do_op(1'b1, 8'h02, 64'h7, 5'd0, lat, rfd, rfr);
        do_op(1'b0, 8'h03, 64'h0, 5'd2, lat, rfd, rfr);
        do_op(1'b1, 8'h04, 64'h8, 5'd0, lat, rfd, rfr);
        do_op(1'b0, 8'h05, 64'h0, 5'd3, lat, rfd, rfr);
        chk("stats_load_count", load_count, 3);
        chk("stats_store_count", store_count, 2);
        @(negedge clk);
        dut.store_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        do_op(1'b1, 8'h06, 64'h9, 5'd0, lat, rfd, rfr);
        chk("stats_store_wrap", store_count, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
